// File: rtl/dlx_pkg.sv
// Shared Extended DLX datapath definitions: field width and the two-way route
// encoding used by the stream demultiplexer.
// Contents: DLX_FIELD_W (payload field width), route_t (ROUTE_A / ROUTE_B).
package dlx_pkg;

  localparam int DLX_FIELD_W = 3;

  typedef enum logic {
    ROUTE_A = 1'b0,
    ROUTE_B = 1'b1
  } route_t;

endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO. Push data is visible at dout one cycle later when empty.
// Full/empty come from the registered occupancy count; push while full and pop
//   while empty are ignored, so neither overflow nor underflow can corrupt state.
// Ports: clk, reset (async, active-high), push/din (write), pop (read advance),
//   dout (head of queue), valid (non-empty), full (count==DEPTH), count (0..DEPTH).
module sync_fifo_small #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  // Flags come straight from the registered count; pointer equality alone
  // cannot tell full from empty.
  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && valid;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux_3_stream.sv
// 1-to-2 stream demultiplexer: each accepted word is steered by in_sel into the
//   A-side or B-side FIFO; accepted data reaches an empty side's output next cycle.
// in_ready reflects only the selected side's registered full flag, so a stalled
//   consumer blocks only traffic destined for its own side.
// Ports: clk, reset (async, active-high); in_data/in_sel/in_valid/in_ready
//   (producer); a_*/b_* data/valid/ready/count (the two consumers).
module demux_3_stream
  import dlx_pkg::*;
#(
  parameter  int WIDTH = DLX_FIELD_W,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  route_t sel_route;
  logic   a_full;
  logic   b_full;
  logic   accept;
  logic   push_a;
  logic   push_b;

  // Readiness uses only the registered full flags: a pop in the same cycle does
  // not open a slot for a push, which keeps consumer ready off the in_ready path.
  always_comb begin
    sel_route = route_t'(in_sel);
    in_ready  = (sel_route == ROUTE_A) ? !a_full : !b_full;
    accept    = in_valid && in_ready;
    push_a    = accept && (sel_route == ROUTE_A);
    push_b    = accept && (sel_route == ROUTE_B);
  end

  sync_fifo_small #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .push  (push_a),
    .din   (in_data),
    .pop   (a_ready),
    .dout  (a_data),
    .valid (a_valid),
    .full  (a_full),
    .count (a_count)
  );

  sync_fifo_small #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .push  (push_b),
    .din   (in_data),
    .pop   (b_ready),
    .dout  (b_data),
    .valid (b_valid),
    .full  (b_full),
    .count (b_count)
  );

endmodule

// File: tb/tb_demux_3_stream.sv
module tb_demux_3_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [2:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [1:0] a_count;
  logic [1:0] b_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per destination plus the popped-word history.
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic [2:0] recv_a[$];
  bit         last_acc;

  always #5 clk = ~clk;

  demux_3_stream dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  // Advance one clock (called just after a negedge) and update the model.
  task automatic tick();
    bit acc, pa, pb;
    logic [2:0] w;
    acc = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    pa  = a_ready && (qa.size() > 0);
    pb  = b_ready && (qb.size() > 0);
    @(posedge clk);
    if (pa) begin
      w = qa.pop_front();
      recv_a.push_back(w);
    end
    if (pb) w = qb.pop_front();
    if (acc) begin
      if (in_sel) qb.push_back(in_data);
      else        qa.push_back(in_data);
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 3'b000;
    a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({a_valid, b_valid, a_count, b_count, a_data, b_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got av=%b bv=%b ac=%0d bc=%0d ad=%b bd=%b expected all zero",
               a_valid, b_valid, a_count, b_count, a_data, b_data);
    end
    in_sel = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_sel0: got %b expected 1", in_ready);
    end
    in_sel = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_sel1: got %b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_routing();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b101;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 3'b101 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_a: got av=%b ad=%b bv=%b expected av=1 ad=101 bv=0", a_valid, a_data, b_valid);
    end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 3'b011;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 3'b011 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_b: got bv=%b bd=%b av=%b expected bv=1 bd=011 av=0", b_valid, b_data, a_valid);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 3'b001; tick();
    in_data = 3'b010; tick();
    in_valid = 1'b0; #1;
    checks++;
    if (a_count !== 2'd2 || a_data !== 3'b001) begin
      errors++; $display("FAIL fill_a: got count=%0d head=%b expected count=2 head=001", a_count, a_data);
    end
    in_sel = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_sel0: got %b expected 0", in_ready);
    end
    in_sel = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_sel1: got %b expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = 3'b111; tick();
    in_valid = 1'b0; #1;
    checks++;
    if (b_count !== 2'd1 || b_data !== 3'b111 || a_count !== 2'd2) begin
      errors++;
      $display("FAIL push_b_while_a_full: got bc=%0d bd=%b ac=%0d expected bc=1 bd=111 ac=2", b_count, b_data, a_count);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    // A holds [001, 010]: push refused, pop proceeds.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b110; a_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_pop_ready: got %b expected 0", in_ready);
    end
    tick(); #1;
    checks++;
    if (a_count !== 2'd1 || a_data !== 3'b010 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_result: got count=%0d head=%b rdy=%b expected count=1 head=010 rdy=1", a_count, a_data, in_ready);
    end
    // Count 1: simultaneous push and pop.
    tick(); #1;
    checks++;
    if (a_count !== 2'd1 || a_data !== 3'b110) begin
      errors++; $display("FAIL push_pop_same: got count=%0d head=%b expected count=1 head=110", a_count, a_data);
    end
    in_valid = 1'b0; tick(); a_ready = 1'b0; #1;
    checks++;
    if (a_count !== 2'd0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL drain_a: got count=%0d valid=%b expected 0 0", a_count, a_valid);
    end
  endtask

  task automatic test_wrap_order();
    int idx = 0;
    recv_a.delete();
    in_sel = 1'b0; b_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && (idx < 8 || qa.size() > 0); cyc++) begin
      in_valid = (idx < 8);
      in_data  = 3'(idx);
      a_ready  = cyc[0];
      #1;
      checks++;
      if (in_ready !== (qa.size() < DEPTH)) begin
        errors++; $display("FAIL wrap_ready cyc%0d: got %b expected %b", cyc, in_ready, qa.size() < DEPTH);
      end
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0; a_ready = 1'b0;
    checks++;
    if (recv_a.size() != 8) begin
      errors++; $display("FAIL wrap_count: got %0d words expected 8", recv_a.size());
    end
    for (int i = 0; i < 8 && i < recv_a.size(); i++) begin
      checks++;
      if (recv_a[i] !== 3'(i)) begin
        errors++; $display("FAIL wrap_order[%0d]: got %b expected %b", i, recv_a[i], 3'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b011; tick();
    in_data = 3'b101; tick();
    in_sel = 1'b1; in_data = 3'b110; tick();
    in_valid = 1'b0; #1;
    checks++;
    if (a_count !== 2'd2 || b_count !== 2'd1) begin
      errors++; $display("FAIL pre_reset_fill: got ac=%0d bc=%0d expected 2 1", a_count, b_count);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({a_valid, b_valid, a_count, b_count, a_data, b_data} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got av=%b bv=%b ac=%0d bc=%0d ad=%b bd=%b expected all zero",
               a_valid, b_valid, a_count, b_count, a_data, b_data);
    end
    #1 reset = 1'b0;
    qa.delete(); qb.delete();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 3'b100; tick();
    in_valid = 1'b0; #1;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 3'b100 || b_count !== 2'd1 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_b: got bv=%b bd=%b bc=%0d av=%b expected 1 100 1 0", b_valid, b_data, b_count, a_valid);
    end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        in_sel   = 1'($urandom);
        in_data  = 3'($urandom);
      end
      a_ready = ($urandom_range(2) != 0);
      b_ready = ($urandom_range(3) == 0);
      #1;
      checks++;
      if (in_ready !== (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)) ||
          a_count !== 2'(qa.size()) || b_count !== 2'(qb.size()) ||
          a_valid !== (qa.size() != 0) || b_valid !== (qb.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: got rdy=%b ac=%0d bc=%0d av=%b bv=%b expected ac=%0d bc=%0d",
                 cyc, in_ready, a_count, b_count, a_valid, b_valid, qa.size(), qb.size());
      end
      if (qa.size() != 0) begin
        checks++;
        if (a_data !== qa[0]) begin
          errors++; $display("FAIL rand_a_data cyc%0d: got %b expected %b", cyc, a_data, qa[0]);
        end
      end
      if (qb.size() != 0) begin
        checks++;
        if (b_data !== qb[0]) begin
          errors++; $display("FAIL rand_b_data cyc%0d: got %b expected %b", cyc, b_data, qb[0]);
        end
      end
      tick();
      // A producer whose offer was refused keeps it stable.
      hold = in_valid && !last_acc;
    end
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_push_pop();
    test_wrap_order();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
